hex_down_timer: RTL and testbench

- Loadable, cascadable hex down-counter/timer. It counts down per enabled clock using a per-digit borrow chain.
- Emits a registered terminal-count pulse and a combinational borrow-out, so several instances chain into wider timers (the borrow-out of one drives the enable of the next).
- Used alongside the hex up-counters as the countdown/timeout source for interval and watchdog timing.

---
 rtl/hex_down_timer.sv | 129 ++++++++++++
 tb/tb_hex_down_timer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/hex_down_timer.sv
// hex_down_timer
//   Loadable, cascadable hex down-counter/timer. The count is built from
//   NDIG 4-bit hex digits that decrement through a per-digit borrow chain.
//   A registered one-cycle terminal-count pulse (tc) and a combinational
//   borrow-out (bo) allow several instances to be chained: the bo of a
//   lower-order stage drives the en of the next higher stage.
//
// Ports
//   clk       in   rising-edge clock
//   res       in   synchronous active-high reset
//   start     in   load load_val and begin counting
//   stop      in   abort counting, return to IDLE
//   en        in   count enable / borrow-in from a lower-order stage
//   reload    in   auto-reload select, sampled at terminal count
//   load_val  in   initial / reload count value (4*NDIG bits)
//   q         out  current count, registered
//   busy      out  high while in RUN
//   bo        out  borrow-out, busy & en & (q == 0), combinational
//   tc        out  terminal-count pulse, registered, one cycle wide
module hex_down_timer #(
   parameter int NDIG = 2
) (
   input  logic              clk,
   input  logic              res,
   input  logic              start,
   input  logic              stop,
   input  logic              en,
   input  logic              reload,
   input  logic [4*NDIG-1:0] load_val,
   output logic [4*NDIG-1:0] q,
   output logic              busy,
   output logic              bo,
   output logic              tc
);

   localparam int W = 4 * NDIG;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   cnt_q, cnt_d;
   logic           tc_q, tc_d;
   logic [W-1:0]   cnt_dec;
   logic [NDIG-1:0] borrow;
   logic           cnt_zero;

   assign cnt_zero = (cnt_q == '0);

   // Borrow chain: digit i steps down when en is high and every lower digit
   // is zero. A digit at 0 that steps wraps to F, so the result equals a
   // plain binary subtract-by-one across the full width.
   assign borrow[0] = en;

   for (genvar i = 0; i < NDIG; i++) begin : g_digit
      assign cnt_dec[4*i +: 4] = borrow[i] ? (cnt_q[4*i +: 4] - 4'd1)
                                           : cnt_q[4*i +: 4];
      if (i < NDIG - 1) begin : g_chain
         assign borrow[i+1] = borrow[i] & (cnt_q[4*i +: 4] == 4'd0);
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (res) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tc_q    <= tc_d;
      end
   end

   // Next-state logic; priority within each state is stop > start > en.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tc_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               cnt_d   = load_val;
               state_d = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
            end else if (start) begin
               cnt_d = load_val;
            end else if (en) begin
               if (!cnt_zero) begin
                  cnt_d = cnt_dec;
               end else begin
                  // Terminal count: pulse tc, then reload or finish.
                  tc_d = 1'b1;
                  if (reload) cnt_d   = load_val;
                  else        state_d = DONE;
               end
            end
         end
         DONE: begin
            if (stop) begin
               state_d = IDLE;
            end else if (start) begin
               cnt_d   = load_val;
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs; bo is unregistered so a chained stage sees it in the same cycle.
   always_comb begin
      busy = (state_q == RUN);
      bo   = (state_q == RUN) & en & cnt_zero;
      q    = cnt_q;
      tc   = tc_q;
   end

endmodule

// File: tb/tb_hex_down_timer.sv
module tb_hex_down_timer;

   logic       clk = 1'b0;
   logic       res, start, stop, en, reload;
   logic [7:0] load_val;
   logic [7:0] q;
   logic       busy, bo, tc;

   // cascade pair
   logic       c_res, c_start, c_reload;
   logic [3:0] c_load;
   logic [3:0] lo_q, hi_q;
   logic       lo_busy, lo_bo, lo_tc, hi_busy, hi_bo, hi_tc;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   hex_down_timer #(.NDIG(2)) dut (
      .clk(clk), .res(res), .start(start), .stop(stop), .en(en),
      .reload(reload), .load_val(load_val), .q(q), .busy(busy),
      .bo(bo), .tc(tc)
   );

   hex_down_timer #(.NDIG(1)) u_lo (
      .clk(clk), .res(c_res), .start(c_start), .stop(1'b0), .en(1'b1),
      .reload(c_reload), .load_val(c_load), .q(lo_q), .busy(lo_busy),
      .bo(lo_bo), .tc(lo_tc)
   );

   hex_down_timer #(.NDIG(1)) u_hi (
      .clk(clk), .res(c_res), .start(c_start), .stop(1'b0), .en(lo_bo),
      .reload(c_reload), .load_val(c_load), .q(hi_q), .busy(hi_busy),
      .bo(hi_bo), .tc(hi_tc)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      res = 1'b1; start = 1'b1; en = 1'b1; stop = 1'b0; reload = 1'b0;
      load_val = 8'h55;
      tick(); tick();
      checks++; if (q !== 8'h00) $display("FAIL reset_q got %h exp 00", q); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
      checks++; if (tc !== 1'b0) $display("FAIL reset_tc got %b exp 0", tc); else passed++;
      checks++; if (bo !== 1'b0) $display("FAIL reset_bo got %b exp 0", bo); else passed++;
      res = 1'b0; start = 1'b0;
      tick(); tick();
      checks++; if (q !== 8'h00 || busy !== 1'b0) $display("FAIL reset_idle got q=%h busy=%b exp q=00 busy=0", q, busy); else passed++;
   endtask

   task automatic test_one_shot();
      logic bad;
      load_val = 8'h05; reload = 1'b0; en = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (q !== 8'h05 || tc !== 1'b0) $display("FAIL oneshot_load got q=%h tc=%b exp q=05 tc=0", q, tc); else passed++;
      for (int k = 1; k <= 5; k++) begin
         tick();
         checks++; if (q !== 8'(5 - k)) $display("FAIL oneshot_count got %h exp %h", q, 8'(5 - k)); else passed++;
      end
      checks++; if (bo !== 1'b1 || tc !== 1'b0 || busy !== 1'b1) $display("FAIL oneshot_bo got bo=%b tc=%b busy=%b exp 1 0 1", bo, tc, busy); else passed++;
      tick();
      checks++; if (tc !== 1'b1 || busy !== 1'b0 || q !== 8'h00 || bo !== 1'b0) $display("FAIL oneshot_tc got tc=%b busy=%b q=%h bo=%b exp 1 0 00 0", tc, busy, q, bo); else passed++;
      bad = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (q !== 8'h00 || tc !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      end
      checks++; if (bad) $display("FAIL oneshot_hold got q=%h tc=%b exp q=00 tc=0 throughout", q, tc); else passed++;
   endtask

   task automatic test_auto_reload();
      logic bad_tc, bad_busy;
      logic [7:0] q2, q3, q4, q19;
      load_val = 8'h12; reload = 1'b1; en = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (q !== 8'h12) $display("FAIL reload_load got %h exp 12", q); else passed++;
      bad_tc = 1'b0; bad_busy = 1'b0;
      q2 = '0; q3 = '0; q4 = '0; q19 = '0;
      for (int k = 1; k <= 38; k++) begin
         tick();
         if (k == 2) q2 = q;
         if (k == 3) q3 = q;
         if (k == 4) q4 = q;
         if (k == 19) q19 = q;
         if (tc !== ((k == 19) || (k == 38))) bad_tc = 1'b1;
         if (busy !== 1'b1) bad_busy = 1'b1;
      end
      checks++; if (q2 !== 8'h10 || q3 !== 8'h0F || q4 !== 8'h0E) $display("FAIL reload_borrow got %h %h %h exp 10 0f 0e", q2, q3, q4); else passed++;
      checks++; if (bad_tc) $display("FAIL reload_period got irregular tc exp tc only at cycles 19 and 38"); else passed++;
      checks++; if (q19 !== 8'h12) $display("FAIL reload_value got %h exp 12", q19); else passed++;
      checks++; if (bad_busy) $display("FAIL reload_busy got busy=0 at some cycle exp 1"); else passed++;
      stop = 1'b1; tick(); stop = 1'b0;
      checks++; if (busy !== 1'b0 || tc !== 1'b0) $display("FAIL reload_stop got busy=%b tc=%b exp 0 0", busy, tc); else passed++;
   endtask

   task automatic test_gated_enable();
      logic [7:0] exp_q [8] = '{8'h02, 8'h02, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
      logic       exp_tc[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic       exp_bo[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      load_val = 8'h03; reload = 1'b0; en = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         en = (i % 2 == 0);
         #1;
         checks++; if (bo !== exp_bo[i]) $display("FAIL gated_bo step %0d got %b exp %b", i, bo, exp_bo[i]); else passed++;
         tick();
         checks++; if (q !== exp_q[i] || tc !== exp_tc[i]) $display("FAIL gated_step %0d got q=%h tc=%b exp q=%h tc=%b", i, q, tc, exp_q[i], exp_tc[i]); else passed++;
      end
   endtask

   task automatic test_priority();
      load_val = 8'h09; reload = 1'b0; en = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      checks++; if (q !== 8'h07) $display("FAIL prio_setup got %h exp 07", q); else passed++;
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      checks++; if (q !== 8'h07 || busy !== 1'b0 || tc !== 1'b0) $display("FAIL prio_stop got q=%h busy=%b tc=%b exp 07 0 0", q, busy, tc); else passed++;
      tick();
      checks++; if (q !== 8'h07) $display("FAIL prio_idle_en got %h exp 07", q); else passed++;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (q !== 8'h09 || busy !== 1'b1) $display("FAIL prio_start got q=%h busy=%b exp 09 1", q, busy); else passed++;
      repeat (5) tick();
      checks++; if (q !== 8'h04) $display("FAIL prio_count got %h exp 04", q); else passed++;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (q !== 8'h09 || tc !== 1'b0 || busy !== 1'b1) $display("FAIL prio_restart got q=%h tc=%b busy=%b exp 09 0 1", q, tc, busy); else passed++;
      load_val = 8'h33;
      tick();
      checks++; if (q !== 8'h08) $display("FAIL prio_loadval_ignored got %h exp 08", q); else passed++;
      stop = 1'b1; tick(); stop = 1'b0;
   endtask

   task automatic test_zero_load();
      load_val = 8'h00; reload = 1'b0; en = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (tc !== 1'b0 || busy !== 1'b1 || bo !== 1'b1) $display("FAIL zero_entry got tc=%b busy=%b bo=%b exp 0 1 1", tc, busy, bo); else passed++;
      tick();
      checks++; if (tc !== 1'b1 || busy !== 1'b0) $display("FAIL zero_tc got tc=%b busy=%b exp 1 0", tc, busy); else passed++;
   endtask

   task automatic test_mid_reset();
      load_val = 8'h02; reload = 1'b1; en = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      res = 1'b1;
      tick();
      res = 1'b0;
      checks++; if (q !== 8'h00 || tc !== 1'b0 || busy !== 1'b0) $display("FAIL midreset got q=%h tc=%b busy=%b exp 00 0 0", q, tc, busy); else passed++;
   endtask

   task automatic test_cascade();
      c_res = 1'b1; c_start = 1'b0; c_reload = 1'b1; c_load = 4'h1;
      tick();
      c_res = 1'b0; c_start = 1'b1;
      tick();
      c_start = 1'b0;
      checks++; if (lo_q !== 4'h1 || hi_q !== 4'h1) $display("FAIL casc_load got lo=%h hi=%h exp 1 1", lo_q, hi_q); else passed++;
      tick();
      checks++; if (lo_q !== 4'h0 || hi_q !== 4'h1) $display("FAIL casc_c1 got lo=%h hi=%h exp 0 1", lo_q, hi_q); else passed++;
      tick();
      checks++; if (lo_q !== 4'h1 || hi_q !== 4'h0 || hi_tc !== 1'b0 || lo_tc !== 1'b1) $display("FAIL casc_c2 got lo=%h hi=%h hitc=%b lotc=%b exp 1 0 0 1", lo_q, hi_q, hi_tc, lo_tc); else passed++;
      tick();
      checks++; if (lo_q !== 4'h0 || hi_q !== 4'h0 || hi_tc !== 1'b0) $display("FAIL casc_c3 got lo=%h hi=%h hitc=%b exp 0 0 0", lo_q, hi_q, hi_tc); else passed++;
      tick();
      checks++; if (hi_tc !== 1'b1 || hi_q !== 4'h1 || hi_busy !== 1'b1 || lo_tc !== 1'b1) $display("FAIL casc_c4 got hitc=%b hi=%h hibusy=%b lotc=%b exp 1 1 1 1", hi_tc, hi_q, hi_busy, lo_tc); else passed++;
   endtask

   initial begin
      res = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b0; reload = 1'b0; load_val = 8'h00;
      c_res = 1'b1; c_start = 1'b0; c_reload = 1'b0; c_load = 4'h0;
      test_reset();
      test_one_shot();
      test_auto_reload();
      test_gated_enable();
      test_priority();
      test_zero_load();
      test_mid_reset();
      test_cascade();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
